// File: rtl/cnn_sched_pkg.sv
// Shared types and default widths for the multi-core CNN job scheduler.
package cnn_sched_pkg;

  localparam int unsigned DefNCores = 4;
  localparam int unsigned DefJobW   = 8;
  localparam int unsigned DefOutW   = 32;

  typedef enum logic [1:0] {
    SlotFree,
    SlotBusy,
    SlotHold
  } slot_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves past the granted index when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (accept) ptr_d = (idx == N - 1) ? '0 : PtrW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multi_core_scheduler.sv
// Dispatches a run of jobs to N_CORES cores and streams back their predictions.
// Define SCHED_PERF_COUNTERS_EN to add the cycle_count and core_jobs counters.
module multi_core_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int unsigned N_CORES = DefNCores,
  parameter int unsigned JOB_W   = DefJobW,
  parameter int unsigned OUT_W   = DefOutW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [JOB_W-1:0]         num_jobs,
  output logic                     busy,
  output logic                     all_done,
  output logic [N_CORES-1:0]       core_start,
  output logic [N_CORES*JOB_W-1:0] core_job_id,
  input  logic [N_CORES-1:0]       core_done,
  input  logic [N_CORES*OUT_W-1:0] core_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [JOB_W-1:0]         res_job_id,
  output logic [OUT_W-1:0]         res_data,
`ifdef SCHED_PERF_COUNTERS_EN
  output logic [31:0]              cycle_count,
  output logic [N_CORES*JOB_W-1:0] core_jobs,
`endif
  output logic                     protocol_err
);

  localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  state_e           state_q, state_d;
  slot_e            slot_q [N_CORES];
  slot_e            slot_d [N_CORES];
  logic [JOB_W-1:0] job_q  [N_CORES];
  logic [JOB_W-1:0] job_d  [N_CORES];
  logic [OUT_W-1:0] hold_q [N_CORES];
  logic [OUT_W-1:0] hold_d [N_CORES];
  logic [JOB_W-1:0] next_job_q, next_job_d;
  logic [JOB_W-1:0] jobs_left_q, jobs_left_d;
  logic [JOB_W-1:0] results_left_q, results_left_d;
  logic             res_valid_q, res_valid_d;
  logic [JOB_W-1:0] res_job_q, res_job_d;
  logic [OUT_W-1:0] res_data_q, res_data_d;
  logic [IdxW-1:0]  res_idx_q, res_idx_d;
  logic             perr_q, perr_d;

  logic               start_ok, res_acc, res_load;
  logic [N_CORES-1:0] busy_vec, hold_vec, presented, req, gnt, launch;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign res_acc  = res_valid_q && res_ready;
  assign res_load = !res_valid_q || res_ready;

  always_comb begin
    busy_vec  = '0;
    hold_vec  = '0;
    presented = '0;
    for (int i = 0; i < N_CORES; i++) begin
      busy_vec[i] = (slot_q[i] == SlotBusy);
      hold_vec[i] = (slot_q[i] == SlotHold);
    end
    if (res_valid_q) presented[res_idx_q] = 1'b1;
  end

  // A core finishing this cycle competes with held slots so it can be presented next cycle.
  assign req = (hold_vec & ~presented) | (core_done & busy_vec);

  rr_arbiter #(
    .N(N_CORES)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .accept(res_load),
    .gnt   (gnt)
  );

  // Reverse scan so the lowest-index free core wins.
  always_comb begin
    launch = '0;
    if (state_q == StRun && jobs_left_q != '0) begin
      for (int i = N_CORES - 1; i >= 0; i--) begin
        if (slot_q[i] == SlotFree) launch = N_CORES'(1) << i;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    job_d          = job_q;
    hold_d         = hold_q;
    next_job_d     = next_job_q;
    jobs_left_d    = jobs_left_q;
    results_left_d = results_left_q;
    res_valid_d    = res_valid_q;
    res_job_d      = res_job_q;
    res_data_d     = res_data_q;
    res_idx_d      = res_idx_q;
    perr_d         = perr_q;

    for (int i = 0; i < N_CORES; i++) begin
      if (core_done[i]) begin
        if (slot_q[i] == SlotBusy) begin
          slot_d[i] = SlotHold;
          hold_d[i] = core_result[i*OUT_W +: OUT_W];
        end else begin
          perr_d = 1'b1;
        end
      end
    end

    if (res_acc) begin
      slot_d[res_idx_q] = SlotFree;
      results_left_d    = results_left_q - JOB_W'(1);
      res_valid_d       = 1'b0;
    end

    if (res_load) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (gnt[i]) begin
          res_valid_d = 1'b1;
          res_job_d   = job_q[i];
          res_data_d  = hold_vec[i] ? hold_q[i] : core_result[i*OUT_W +: OUT_W];
          res_idx_d   = IdxW'(i);
        end
      end
    end

    for (int i = 0; i < N_CORES; i++) begin
      if (launch[i]) begin
        slot_d[i] = SlotBusy;
        job_d[i]  = next_job_q;
      end
    end
    if (launch != '0) begin
      next_job_d  = next_job_q + JOB_W'(1);
      jobs_left_d = jobs_left_q - JOB_W'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          next_job_d     = '0;
          jobs_left_d    = num_jobs;
          results_left_d = num_jobs;
          state_d        = (num_jobs == '0) ? StDone : StRun;
        end
      end
      StRun:   if (jobs_left_d == '0) state_d = StDrain;
      StDrain: if (results_left_q == '0) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      next_job_q     <= '0;
      jobs_left_q    <= '0;
      results_left_q <= '0;
      res_valid_q    <= 1'b0;
      res_job_q      <= '0;
      res_data_q     <= '0;
      res_idx_q      <= '0;
      perr_q         <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        slot_q[i] <= SlotFree;
        job_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      next_job_q     <= next_job_d;
      jobs_left_q    <= jobs_left_d;
      results_left_q <= results_left_d;
      res_valid_q    <= res_valid_d;
      res_job_q      <= res_job_d;
      res_data_q     <= res_data_d;
      res_idx_q      <= res_idx_d;
      perr_q         <= perr_d;
      slot_q         <= slot_d;
      job_q          <= job_d;
      hold_q         <= hold_d;
    end
  end

  // The launching core sees its new ID in the same cycle as its start pulse.
  always_comb begin
    core_job_id = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_job_id[i*JOB_W +: JOB_W] = launch[i] ? next_job_q : job_q[i];
    end
  end

  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign all_done     = (state_q == StDone);
  assign core_start   = launch;
  assign res_valid    = res_valid_q;
  assign res_job_id   = res_job_q;
  assign res_data     = res_data_q;
  assign protocol_err = perr_q;

`ifdef SCHED_PERF_COUNTERS_EN
  logic [31:0]              cycle_q, cycle_d;
  logic [N_CORES*JOB_W-1:0] cjobs_q, cjobs_d;

  always_comb begin
    cycle_d = cycle_q;
    cjobs_d = cjobs_q;
    if (start_ok) begin
      cycle_d = '0;
      cjobs_d = '0;
    end else begin
      if (busy && cycle_q != '1) cycle_d = cycle_q + 32'd1;
      for (int i = 0; i < N_CORES; i++) begin
        if (launch[i]) cjobs_d[i*JOB_W +: JOB_W] = cjobs_q[i*JOB_W +: JOB_W] + JOB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      cjobs_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      cjobs_q <= cjobs_d;
    end
  end

  assign cycle_count = cycle_q;
  assign core_jobs   = cjobs_q;
`endif

endmodule

// File: tb/tb_multi_core_scheduler.sv
// Directed bench for multi_core_scheduler: behavioural core models plus a result scoreboard.
module tb_multi_core_scheduler;

  localparam int N  = 4;
  localparam int JW = 8;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [JW-1:0]   num_jobs;
  logic            busy, all_done;
  logic [N-1:0]    core_start;
  logic [N*JW-1:0] core_job_id;
  logic [N-1:0]    core_done, model_done, spur_done;
  logic [N*OW-1:0] core_result;
  logic            res_valid, res_ready;
  logic [JW-1:0]   res_job_id;
  logic [OW-1:0]   res_data;
  logic            protocol_err;
`ifdef SCHED_PERF_COUNTERS_EN
  logic [31:0]     cycle_count;
  logic [N*JW-1:0] core_jobs;
`endif

  assign core_done = model_done | spur_done;

  always #5 clk = ~clk;

  multi_core_scheduler #(
    .N_CORES(N),
    .JOB_W  (JW),
    .OUT_W  (OW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_jobs    (num_jobs),
    .busy        (busy),
    .all_done    (all_done),
    .core_start  (core_start),
    .core_job_id (core_job_id),
    .core_done   (core_done),
    .core_result (core_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_job_id  (res_job_id),
    .res_data    (res_data),
`ifdef SCHED_PERF_COUNTERS_EN
    .cycle_count (cycle_count),
    .core_jobs   (core_jobs),
`endif
    .protocol_err(protocol_err)
  );

  typedef struct {
    int            job;
    logic [OW-1:0] data;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   lat [N];
  int   cnt [N];
  int   job_of [N];
  bit   owned [N];
  int   core_of [256];
  int   n_run, next_exp, launched, accepted, start_cyc;
  bit   stall, exp_relaunch, prev_valid;
  exp_t sb [$];
  int   launch_core [$], launch_cyc [$], acc_core [$], acc_cyc [$], done_cyc [$], valid_cyc [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Core models and result consumer, all acting on the falling edge.
  initial begin
    model_done   = '0;
    core_result  = '0;
    res_ready    = 1'b1;
    exp_relaunch = 1'b0;
    prev_valid   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      owned[i] = 1'b0;
      job_of[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        model_done   = '0;
        exp_relaunch = 1'b0;
        prev_valid   = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) begin
          cnt[i]   = 0;
          owned[i] = 1'b0;
        end
        res_ready = !stall;
      end else begin
        if (exp_relaunch) check("relaunch_next_cycle", core_start != '0, 1);
        exp_relaunch = 1'b0;
        if (res_valid && !prev_valid) valid_cyc.push_back(cyc);
        prev_valid = res_valid;

        model_done = '0;
        for (int i = 0; i < N; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              exp_t e;
              e.job  = job_of[i];
              e.data = OW'(job_of[i] + 100);
              model_done[i]              = 1'b1;
              core_result[i*OW +: OW]    = e.data;
              sb.push_back(e);
              done_cyc.push_back(cyc);
            end
          end
        end

        if (core_start != '0) check("one_launch_per_cycle", $countones(core_start), 1);
        for (int i = 0; i < N; i++) begin
          if (core_start[i]) begin
            check("launch_into_free_core", owned[i], 0);
            check("launch_job_id", core_job_id[i*JW +: JW], next_exp);
            owned[i]  = 1'b1;
            job_of[i] = int'(core_job_id[i*JW +: JW]);
            core_of[job_of[i]] = i;
            cnt[i]    = lat[i];
            next_exp++;
            launched++;
            launch_core.push_back(i);
            launch_cyc.push_back(cyc);
          end
        end

        res_ready = !stall;
        if (res_valid && res_ready) begin
          int k;
          int c;
          k = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (k < 0 && sb[j].job == int'(res_job_id)) k = j;
          end
          check("res_job_known", k >= 0, 1);
          if (k >= 0) begin
            check("res_data", res_data, sb[k].data);
            sb.delete(k);
          end
          c = core_of[res_job_id];
          owned[c] = 1'b0;
          acc_core.push_back(c);
          acc_cyc.push_back(cyc);
          accepted++;
          exp_relaunch = (launched < n_run);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a;
    lat[1] = b;
    lat[2] = c;
    lat[3] = d;
  endtask

  task automatic begin_run(input int n);
    n_run    = n;
    next_exp = 0;
    launched = 0;
    accepted = 0;
    launch_core.delete();
    launch_cyc.delete();
    acc_core.delete();
    acc_cyc.delete();
    done_cyc.delete();
    valid_cyc.delete();
    start     = 1'b1;
    num_jobs  = JW'(n);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (!all_done && k < limit) begin
      tick();
      k++;
    end
    check({tag, "_all_done"}, all_done, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic run_totals(input string tag, input int n);
    check({tag, "_launched"}, launched, n);
    check({tag, "_accepted"}, accepted, n);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    logic [JW-1:0] j0;
    logic [OW-1:0] d0;
    int            k;

    rst       = 1'b1;
    start     = 1'b0;
    num_jobs  = '0;
    stall     = 1'b0;
    spur_done = '0;
    n_run     = 0;
    set_lat(10, 10, 10, 10);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_all_done", all_done, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_job_id", core_job_id, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_protocol_err", protocol_err, 0);
    rst = 1'b0;
    tick();

    // Basic run: four jobs on four idle cores.
    begin_run(4);
    check("basic_busy", busy, 1);
    wait_done("basic", 200);
    run_totals("basic", 4);
    check("basic_launch_count", launch_core.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("basic_launch_core", launch_core[i], i);
      check("basic_launch_cycle", launch_cyc[i], start_cyc + 1 + i);
    end
    check("basic_first_res_latency", valid_cyc[0], done_cyc[0] + 1);
    check("basic_no_protocol_err", protocol_err, 0);

    // Oversubscription with staggered latencies.
    set_lat(3, 7, 11, 5);
    begin_run(10);
    wait_done("over", 600);
    run_totals("over", 10);

    // Backpressure while all four cores finish together, with a fifth job pending.
    set_lat(13, 12, 11, 10);
    stall = 1'b1;
    begin_run(5);
    k = 0;
    while (done_cyc.size() < 4 && k < 100) begin
      tick();
      k++;
    end
    check("bp_four_done", done_cyc.size(), 4);
    check("bp_simultaneous", done_cyc[3], done_cyc[0]);
    tick();
    j0 = res_job_id;
    d0 = res_data;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid_held", res_valid, 1);
      check("bp_job_stable", res_job_id, j0);
      check("bp_data_stable", res_data, d0);
      check("bp_no_launch", core_start, 0);
      tick();
    end
    stall = 1'b0;
    wait_done("bp", 300);
    run_totals("bp", 5);
    for (int i = 0; i < 3; i++) begin
      check("bp_drain_back_to_back", acc_cyc[i+1], acc_cyc[i] + 1);
      check("bp_drain_rr_order", acc_core[i+1], (acc_core[i] + 1) % N);
    end

    // Zero-job run.
    begin_run(0);
    check("zero_all_done", all_done, 1);
    for (int i = 0; i < 4; i++) begin
      check("zero_busy_low", busy, 0);
      tick();
    end
    check("zero_no_launch", launched, 0);

    // Start pulse during RUN must be ignored.
    set_lat(6, 6, 6, 6);
    begin_run(6);
    tick();
    check("mid_busy", busy, 1);
    start    = 1'b1;
    num_jobs = JW'(2);
    tick();
    start = 1'b0;
    wait_done("mid", 300);
    run_totals("mid", 6);

    // Restart from DONE.
    set_lat(4, 4, 4, 4);
    begin_run(3);
    check("restart_all_done_low", all_done, 0);
    check("restart_busy", busy, 1);
    check("restart_first_launch", launch_cyc.size(), 1);
    wait_done("restart", 200);
    run_totals("restart", 3);

    // Asynchronous reset while draining.
    set_lat(30, 30, 30, 30);
    begin_run(4);
    repeat (6) tick();
    check("drain_busy", busy, 1);
    check("drain_launched", launched, 4);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_core_start", core_start, 0);
    check("arst_core_job_id", core_job_id, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_all_done", all_done, 0);
    tick();
    tick();
    rst = 1'b0;
    n_run = 0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_all_done", all_done, 0);
    check("post_rst_perr", protocol_err, 0);

    // Spurious completion from an idle core.
    spur_done = 4'b0100;
    tick();
    spur_done = '0;
    tick();
    check("spurious_perr", protocol_err, 1);
    repeat (3) tick();
    check("spurious_perr_sticky", protocol_err, 1);

    // All slots free again after reset.
    set_lat(5, 5, 5, 5);
    begin_run(2);
    wait_done("after_rst", 200);
    run_totals("after_rst", 2);
    check("after_rst_perr_sticky", protocol_err, 1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
